// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared FSM encoding and constants for the instruction fetch controller
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_HALT = 2'd3
  } fetch_state_e;

  // Bubble presented to decode when no instruction is valid
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Byte address to 32-bit word index
  localparam int WORD_SHIFT = 2;

  function automatic logic [31:0] word_index(input logic [31:0] addr);
    return addr >> WORD_SHIFT;
  endfunction

  // Clears the byte-offset bits so every fetch is word aligned
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return (addr >> WORD_SHIFT) << WORD_SHIFT;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - single-entry data+address skid register with valid, load/clear/pop
module fetch_skid_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        clear,
  input  logic        pop,
  input  logic [31:0] load_data,
  input  logic [31:0] load_addr,
  output logic        valid,
  output logic [31:0] data,
  output logic [31:0] addr
);

  // Clear wins over load so a redirect always empties the entry; pop only drops valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= 32'h0;
      addr  <= 32'h0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      addr  <= load_addr;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch controller; FETCH_BOUND_CHECK_EN adds the out-of-range halt
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        mem_en_o,
  output logic [31:0] mem_addr_o,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        instr_valid_o,
  output logic        fetch_err_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic         inflight_q, inflight_d;
  logic [31:0]  inflight_addr_q, inflight_addr_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc_q, pc_d;
  logic         valid_q, valid_d;
  logic         err_q, err_d;

  logic         issue;
  logic [31:0]  issue_addr;
  logic         oor;

  logic         skid_load, skid_clear, skid_pop;
  logic         skid_valid;
  logic [31:0]  skid_data, skid_addr;

  // A fetch is wanted in RUN/HOLD unless stalled; a redirect always fetches its target
  assign issue      = ((state_q == ST_RUN) || (state_q == ST_HOLD)) && (redirect_i || !stall_i);
  assign issue_addr = redirect_i ? align_word(redirect_pc_i) : fetch_pc_q;

`ifdef FETCH_BOUND_CHECK_EN
  assign oor = word_index(issue_addr) >= 32'(MEM_WORDS);
`else
  // Depth only matters when the bound check is built in
  logic unused_mem_words;
  assign unused_mem_words = ^32'(MEM_WORDS);
  assign oor = 1'b0;
`endif

  assign mem_en_o      = issue && !oor;
  assign mem_addr_o    = issue_addr;
  assign instr_o       = instr_q;
  assign pc_o          = pc_q;
  assign instr_valid_o = valid_q;
  assign fetch_err_o   = err_q;

  fetch_skid_buf u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (skid_load),
    .clear     (skid_clear),
    .pop       (skid_pop),
    .load_data (mem_rdata_i),
    .load_addr (inflight_addr_q),
    .valid     (skid_valid),
    .data      (skid_data),
    .addr      (skid_addr)
  );

  // Next-state, presentation and skid control
  always_comb begin
    state_d         = state_q;
    fetch_pc_d      = fetch_pc_q;
    inflight_d      = 1'b0;
    inflight_addr_d = inflight_addr_q;
    instr_d         = instr_q;
    pc_d            = pc_q;
    valid_d         = valid_q;
    err_d           = err_q;
    skid_load       = 1'b0;
    skid_clear      = 1'b0;
    skid_pop        = 1'b0;

    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN, ST_HOLD: begin
        if (redirect_i) begin
          // Flush: drop the in-flight return and the skid, show a bubble
          skid_clear = 1'b1;
          instr_d    = NOP_INSTR;
          valid_d    = 1'b0;
          state_d    = stall_i ? ST_HOLD : ST_RUN;
        end else if (stall_i) begin
          // Outputs hold; catch whatever the memory returns this cycle
          skid_load = inflight_q;
          state_d   = ST_HOLD;
        end else begin
          state_d = ST_RUN;
          if (skid_valid) begin
            instr_d  = skid_data;
            pc_d     = skid_addr;
            valid_d  = 1'b1;
            skid_pop = 1'b1;
          end else if (inflight_q) begin
            instr_d = mem_rdata_i;
            pc_d    = inflight_addr_q;
            valid_d = 1'b1;
          end else begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
          end
        end
      end
      default: valid_d = 1'b0;
    endcase

    if (issue && !oor) begin
      inflight_d      = 1'b1;
      inflight_addr_d = issue_addr;
      fetch_pc_d      = issue_addr + 32'd4;
    end else if (issue && oor) begin
      err_d   = 1'b1;
      valid_d = 1'b0;
      state_d = ST_HALT;
    end
  end

  // State and output registers; reset also forgets any read in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_BOOT;
      fetch_pc_q      <= RESET_PC;
      inflight_q      <= 1'b0;
      inflight_addr_q <= RESET_PC;
      instr_q         <= NOP_INSTR;
      pc_q            <= RESET_PC;
      valid_q         <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      fetch_pc_q      <= fetch_pc_d;
      inflight_q      <= inflight_d;
      inflight_addr_q <= inflight_addr_d;
      instr_q         <= instr_d;
      pc_q            <= pc_d;
      valid_q         <= valid_d;
      err_q           <= err_d;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking bench for fetch_ctrl: cycle table plus in-order scoreboard
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_en, instr_valid, fetch_err;
  logic [31:0] mem_addr, instr, pc;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        en;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
  } row_t;

  row_t rows[23];
  int   last_row;

  fetch_ctrl #(.RESET_PC(32'h0), .MEM_WORDS(1024)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .mem_en_o      (mem_en),
    .mem_addr_o    (mem_addr),
    .mem_rdata_i   (mem_rdata),
    .instr_o       (instr),
    .pc_o          (pc),
    .instr_valid_o (instr_valid),
    .fetch_err_o   (fetch_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return 32'h8000_0000 | (a >> 2);
  endfunction

  // Synchronous instruction memory, one-cycle read latency
  always @(posedge clk) if (mem_en) mem_rdata <= word_of(mem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic row_t mk(input logic s, input logic r, input logic [31:0] rpc,
                              input logic en, input logic [31:0] a, input logic v, input logic [31:0] p);
    row_t t;
    t.stall = s; t.redir = r; t.rpc = rpc; t.en = en; t.addr = a; t.valid = v; t.pc = p;
    return t;
  endfunction

  // Every instruction accepted by decode must be the next one in the expected stream
  always @(negedge clk) begin
    if (rst_n && instr_valid && !stall) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected actual_pc=%h expected=none", pc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("sb_pc", pc, e);
        chk("sb_instr", instr, word_of(e));
      end
    end
  end

  // Caller is aligned 1 time unit after a rising edge; each row is one clock cycle
  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      stall       = rows[i].stall;
      redirect    = rows[i].redir;
      redirect_pc = rows[i].rpc;
      if (rows[i].valid && !rows[i].stall) exp_q.push_back(rows[i].pc);
      @(negedge clk);
      chk($sformatf("row%0d_en", i), {31'h0, mem_en}, {31'h0, rows[i].en});
      if (rows[i].en) chk($sformatf("row%0d_addr", i), mem_addr, rows[i].addr);
      chk($sformatf("row%0d_valid", i), {31'h0, instr_valid}, {31'h0, rows[i].valid});
      if (rows[i].valid) chk($sformatf("row%0d_pc", i), pc, rows[i].pc);
      else chk($sformatf("row%0d_bubble", i), instr, 32'h0);
      chk($sformatf("row%0d_err", i), {31'h0, fetch_err}, 32'h0);
      @(posedge clk);
      #1;
    end
    stall    = 1'b0;
    redirect = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //              stall redir rpc            en addr           valid pc
    rows[0]  = mk(0, 0, 32'h0,          0, 32'h0,          0, 32'h0);
    rows[1]  = mk(0, 0, 32'h0,          1, 32'h0,          0, 32'h0);
    rows[2]  = mk(0, 0, 32'h0,          1, 32'h4,          0, 32'h0);
    rows[3]  = mk(0, 0, 32'h0,          1, 32'h8,          1, 32'h0);
    rows[4]  = mk(0, 0, 32'h0,          1, 32'hc,          1, 32'h4);
    rows[5]  = mk(1, 0, 32'h0,          0, 32'h0,          1, 32'h8);
    rows[6]  = mk(1, 0, 32'h0,          0, 32'h0,          1, 32'h8);
    rows[7]  = mk(1, 0, 32'h0,          0, 32'h0,          1, 32'h8);
    rows[8]  = mk(0, 0, 32'h0,          1, 32'h10,         1, 32'h8);
    rows[9]  = mk(0, 0, 32'h0,          1, 32'h14,         1, 32'hc);
    rows[10] = mk(0, 1, 32'h103,        1, 32'h100,        1, 32'h10);
    rows[11] = mk(0, 0, 32'h0,          1, 32'h104,        0, 32'h0);
    rows[12] = mk(0, 0, 32'h0,          1, 32'h108,        1, 32'h100);
    rows[13] = mk(1, 1, 32'h100,        1, 32'h100,        1, 32'h104);
    rows[14] = mk(1, 0, 32'h0,          0, 32'h0,          0, 32'h0);
    rows[15] = mk(0, 0, 32'h0,          1, 32'h104,        0, 32'h0);
    rows[16] = mk(0, 0, 32'h0,          1, 32'h108,        1, 32'h100);
    rows[17] = mk(0, 0, 32'h0,          1, 32'h10c,        1, 32'h104);
    rows[18] = mk(0, 0, 32'h0,          1, 32'h110,        1, 32'h108);
    rows[19] = mk(0, 1, 32'hffff_fffe,  1, 32'hffff_fffc,  1, 32'h10c);
    rows[20] = mk(0, 0, 32'h0,          1, 32'h0,          0, 32'h0);
    rows[21] = mk(0, 0, 32'h0,          1, 32'h4,          1, 32'hffff_fffc);
    rows[22] = mk(0, 0, 32'h0,          1, 32'h8,          1, 32'h0);
`ifdef FETCH_BOUND_CHECK_EN
    last_row = 18;
`else
    last_row = 22;
`endif

    // Reset values while held in reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_en", {31'h0, mem_en}, 32'h0);
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_err", {31'h0, fetch_err}, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    run_rows(0, last_row);

    // Stall so the skid fills, then reset asynchronously mid-cycle
    stall = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("mid_rst_instr", instr, 32'h0);
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_en", {31'h0, mem_en}, 32'h0);
    chk("mid_rst_err", {31'h0, fetch_err}, 32'h0);
    stall = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_rows(0, 12);

`ifdef FETCH_BOUND_CHECK_EN
    // Redirect beyond the memory: halt with sticky error until reset
    redirect    = 1'b1;
    redirect_pc = 32'h0000_1000;
    exp_q.push_back(32'h104);
    @(negedge clk);
    chk("oob_en", {31'h0, mem_en}, 32'h0);
    @(posedge clk);
    #1 redirect = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("halt%0d_err", k), {31'h0, fetch_err}, 32'h1);
      chk($sformatf("halt%0d_en", k), {31'h0, mem_en}, 32'h0);
      chk($sformatf("halt%0d_valid", k), {31'h0, instr_valid}, 32'h0);
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    chk("halt_rst_err", {31'h0, fetch_err}, 32'h0);
`endif

    chk("sb_drain", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, byte address of the first fetch after reset.
REQ-002 Parameter MEM_WORDS, default 1024, instruction memory depth in 32-bit words.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 stall_i  input  1  decode cannot accept; hold presented instruction.
REQ-006 redirect_i  input  1  branch/jump taken; flush and refetch.
REQ-007 redirect_pc_i  input  32  redirect target byte address.
REQ-008 mem_en_o  output  1  read strobe to synchronous instruction memory.
REQ-009 mem_addr_o  output  32  byte address of the read; memory indexes word addr>>2.
REQ-010 mem_rdata_i  input  32  memory data, valid exactly 1 cycle after mem_en_o.
REQ-011 instr_o  output  32  instruction presented to decode.
REQ-012 pc_o  output  32  byte address of instr_o.
REQ-013 instr_valid_o  output  1  instr_o/pc_o valid.
REQ-014 fetch_err_o  output  1  out-of-range fetch flag (see Configuration).

Function
REQ-015 FSM states BOOT, RUN, HOLD, HALT; reset enters BOOT.
REQ-016 BOOT lasts one cycle, issues no fetch, then moves to RUN.
REQ-017 In RUN with stall_i=0, mem_en_o=1 every cycle; mem_addr_o = previous issued address +4 (RESET_PC for the first issue).
REQ-018 Read latency 1: data returned in cycle N+1 drives instr_o, pc_o = address issued in cycle N, instr_valid_o=1, all registered; first valid instruction on the 3rd rising edge after rst_n deasserts.
REQ-019 stall_i=1 in RUN: mem_en_o=0, instr_o/pc_o/instr_valid_o hold, FSM to HOLD; data returning that cycle is captured into a one-entry skid register with its address.
REQ-020 HOLD with stall_i=0: skid entry (if valid) presented next, then fetching resumes at skid address +4; no instruction is dropped or duplicated; FSM to RUN.
REQ-021 redirect_i=1 in RUN or HOLD: takes priority over stall_i; mem_en_o=1, mem_addr_o = {redirect_pc_i[31:2],2'b00} combinationally in that cycle; in-flight return and skid discarded; next cycle instr_o=0, instr_valid_o=0 unless stall_i; target instruction valid the cycle after that.
REQ-022 Address increment wraps modulo 2^32; redirect_pc_i[1:0] ignored.
REQ-023 redirect_i and stall_i both 1: redirect fetch issued, skid cleared, FSM to HOLD with returned target data held in skid.

Reset
REQ-024 rst_n low asynchronously forces: state BOOT, instr_o=0, pc_o=RESET_PC, instr_valid_o=0, mem_en_o=0, skid invalid, fetch_err_o=0.
REQ-025 Reset mid-fetch discards any in-flight read; no output derived from it after reset.

Configuration
REQ-026 Macro FETCH_BOUND_CHECK_EN defined: any issued address with word index >= MEM_WORDS suppresses mem_en_o, sets fetch_err_o=1 (sticky), instr_valid_o=0, FSM to HALT; only reset leaves HALT.
REQ-027 Macro undefined: no check, fetch_err_o tied 0, HALT unreachable, address passes unmodified.

Structure
REQ-028 Shared package holds FSM state encoding, NOP/bubble constant 32'h0, and word-address shift constant 2.
REQ-029 One sub-module fetch_skid_buf (single-entry data+address register with valid, load/clear/pop).

Verification
REQ-030 Reset release, RESET_PC=0, no stall -> mem_addr_o 0,4,8,...; instr_valid_o on 3rd edge with pc_o=0, then pc_o increments by 4 each cycle.
REQ-031 stall_i high 3 cycles while pc_o=8 -> instr_o/pc_o held at 8, mem_en_o=0; after release pc_o sequence 12,16 with no gap or repeat.
REQ-032 redirect_i with redirect_pc_i=32'h0000_0103 at pc_o=16 -> mem_addr_o=32'h100 same cycle, one bubble (instr_valid_o=0, instr_o=0), then pc_o=32'h100.
REQ-033 redirect_i and stall_i together -> skid holds 32'h100 data; on stall release pc_o=32'h100, then 32'h104.
REQ-034 rst_n asserted mid-stream with skid valid -> all outputs return to reset values immediately; restart from RESET_PC.
REQ-035 FETCH_BOUND_CHECK_EN, MEM_WORDS=1024, redirect to 32'h1000 -> fetch_err_o=1, mem_en_o=0, instr_valid_o=0 until reset.
